// File: rtl/moore_seq_pkg.sv
// -----------------------------------------------------------------------------
// moore_seq_pkg
//   Shared helpers for the parametrised Moore serial-pattern detector.
//   - clog2      : ceiling log2, used to size the state register.
//   - kmp_next   : next matched-prefix length from state k on input bit b.
//   - kmp_fail   : longest proper prefix that is also a suffix of the pattern.
//   - S0         : idle / nothing-matched state index.
//   The detector's DETECT state index equals its pattern length, so it is
//   derived inside the detector from PAT_LEN.
//   Pattern convention: pat[len-1] is the first bit received, pat[0] the last.
// -----------------------------------------------------------------------------
package moore_seq_pkg;

  localparam int S0          = 0;
  localparam int MAX_PAT_LEN = 16;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Longest prefix of the pattern that is a suffix of
  // (first k pattern bits followed by b). Requires k < len.
  function automatic int kmp_next(input logic [MAX_PAT_LEN-1:0] pat,
                                  input int len,
                                  input int k,
                                  input logic b);
    logic [MAX_PAT_LEN:0] s;
    logic                 ok;
    int                   res;
    s   = '0;
    res = 0;
    for (int i = 0; i < MAX_PAT_LEN; i++) begin
      if (i < k) s[i] = pat[len-1-i];
    end
    s[k] = b;
    // Ascending scan, so the last hit is the longest one.
    for (int j = 1; j <= MAX_PAT_LEN; j++) begin
      if (j <= k + 1 && j <= len) begin
        ok = 1'b1;
        for (int i = 0; i < MAX_PAT_LEN; i++) begin
          if (i < j && pat[len-1-i] != s[k+1-j+i]) ok = 1'b0;
        end
        if (ok) res = j;
      end
    end
    return res;
  endfunction

  // Longest proper prefix of the pattern that is also a suffix of it.
  function automatic int kmp_fail(input logic [MAX_PAT_LEN-1:0] pat,
                                  input int len);
    logic ok;
    int   res;
    res = 0;
    for (int j = 1; j < MAX_PAT_LEN; j++) begin
      if (j < len) begin
        ok = 1'b1;
        for (int i = 0; i < MAX_PAT_LEN; i++) begin
          if (i < j && pat[len-1-i] != pat[j-1-i]) ok = 1'b0;
        end
        if (ok) res = j;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/moore_seq_match_cnt.sv
// -----------------------------------------------------------------------------
// moore_seq_match_cnt
//   Saturating up-counter of detected matches.
//   Ports:
//     clock  in   1  rising-edge clock
//     reset  in   1  synchronous active-high clear
//     inc    in   1  count one match this edge
//     count  out  W  match count, sticks at 2^W-1
// -----------------------------------------------------------------------------
module moore_seq_match_cnt #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/moore_seq_detect_param.sv
// -----------------------------------------------------------------------------
// moore_seq_detect_param
//   Parametrised Moore serial-pattern detector. The transition table is the
//   KMP automaton of PATTERN, built at elaboration from moore_seq_pkg.
//   Optional feature macro: MATCH_CNT_EN (adds a saturating match counter).
//
//   state        | meaning
//   -------------+------------------------------------------------
//   S0           | no pattern bits matched (idle)
//   S1..S(L-1)   | first k pattern bits matched
//   DETECT (=SL) | full pattern seen; y = 1
//
//   Ports:
//     clock        in   1      rising-edge clock
//     reset        in   1      synchronous active-high reset
//     x            in   1      serial data bit
//     en           in   1      bit valid; x sampled only when en = 1
//     y            out  1      high while state == DETECT
//     match_count  out  CNT_W  saturating match count (MATCH_CNT_EN only)
// -----------------------------------------------------------------------------
module moore_seq_detect_param
  import moore_seq_pkg::*;
#(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1010,
  parameter bit                 OVERLAP = 1'b1,
  parameter int                 CNT_W   = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             x,
  input  logic             en,
  output logic             y
`ifdef MATCH_CNT_EN
  ,
  output logic [CNT_W-1:0] match_count
`endif
);

  localparam int              SW        = clog2(PAT_LEN + 1);
  localparam int              NSTATE    = 2 ** SW;
  localparam int              FAIL      = kmp_fail(MAX_PAT_LEN'(PATTERN), PAT_LEN);
  localparam int              DETECT    = PAT_LEN;
  localparam logic [SW-1:0]   ST_S0     = SW'(S0);
  localparam logic [SW-1:0]   ST_DETECT = SW'(DETECT);

  if (PAT_LEN < 2 || PAT_LEN > MAX_PAT_LEN) begin : g_bad_len
    $error("moore_seq_detect_param: PAT_LEN must be 2..16");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("moore_seq_detect_param: CNT_W must be >= 1");
  end

  logic [SW-1:0] state;
  logic [SW-1:0] state_nxt;
  logic [SW-1:0] nxt0_tab [NSTATE];
  logic [SW-1:0] nxt1_tab [NSTATE];

  // Table is padded to the full encoding range; unreachable codes fall back
  // to S0 so a corrupted state recovers on the next enabled bit.
  for (genvar k = 0; k < NSTATE; k++) begin : g_tab
    if (k <= PAT_LEN) begin : g_live
      // DETECT behaves like S(FAIL) when overlapping, otherwise like S0.
      localparam int SRC = (k == PAT_LEN) ? (OVERLAP ? FAIL : S0) : k;
      localparam int N0  = kmp_next(MAX_PAT_LEN'(PATTERN), PAT_LEN, SRC, 1'b0);
      localparam int N1  = kmp_next(MAX_PAT_LEN'(PATTERN), PAT_LEN, SRC, 1'b1);
      assign nxt0_tab[k] = N0[SW-1:0];
      assign nxt1_tab[k] = N1[SW-1:0];
    end else begin : g_pad
      assign nxt0_tab[k] = ST_S0;
      assign nxt1_tab[k] = ST_S0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_S0;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (en) begin
      state_nxt = x ? nxt1_tab[state] : nxt0_tab[state];
    end
  end

  // Pure state decode: x and en have no combinational path to y.
  assign y = (state == ST_DETECT);

`ifdef MATCH_CNT_EN
  logic hit;

  assign hit = en && (state_nxt == ST_DETECT);

  moore_seq_match_cnt #(
    .W (CNT_W)
  ) u_match_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (hit),
    .count (match_count)
  );
`endif

endmodule

// File: tb/tb_moore_seq_detect_param.sv
// -----------------------------------------------------------------------------
// tb_moore_seq_detect_param
//   Three detector instances share one input stream:
//     0: 1010, overlapping       1: 1010, non-overlapping
//     2: 111, overlapping, CNT_W = 2
//   The reference model keeps the raw history of enabled bits and declares a
//   match when its last PAT_LEN bits equal the pattern; non-overlapping mode
//   forgets the history after each match.
// -----------------------------------------------------------------------------
module tb_moore_seq_detect_param;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       x     = 1'b0;
  logic       en    = 1'b0;
  logic [2:0] y_dut;
`ifdef MATCH_CNT_EN
  logic [7:0] cnt0;
  logic [7:0] cnt1;
  logic [1:0] cnt2;
`endif

  int errors = 0;
  int checks = 0;
  int nstep  = 0;

  always #5 clock = ~clock;

  moore_seq_detect_param #(
    .PAT_LEN (4), .PATTERN (4'b1010), .OVERLAP (1'b1), .CNT_W (8)
  ) dut_ov (
    .clock (clock), .reset (reset), .x (x), .en (en), .y (y_dut[0])
`ifdef MATCH_CNT_EN
    , .match_count (cnt0)
`endif
  );

  moore_seq_detect_param #(
    .PAT_LEN (4), .PATTERN (4'b1010), .OVERLAP (1'b0), .CNT_W (8)
  ) dut_nov (
    .clock (clock), .reset (reset), .x (x), .en (en), .y (y_dut[1])
`ifdef MATCH_CNT_EN
    , .match_count (cnt1)
`endif
  );

  moore_seq_detect_param #(
    .PAT_LEN (3), .PATTERN (3'b111), .OVERLAP (1'b1), .CNT_W (2)
  ) dut_111 (
    .clock (clock), .reset (reset), .x (x), .en (en), .y (y_dut[2])
`ifdef MATCH_CNT_EN
    , .match_count (cnt2)
`endif
  );

  // Reference model state
  int          plen [3] = '{4, 4, 3};
  logic [15:0] ppat [3] = '{16'hA, 16'hA, 16'h7};
  bit          pov  [3] = '{1'b1, 1'b0, 1'b1};
  int          cmax [3] = '{255, 255, 3};
  logic [63:0] hist [3];
  int          nbits[3];
  logic        ey   [3];
  int          ecnt [3];

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s step=%0d got=%0h exp=%0h", tag, nstep, got, exp);
    end
  endtask

  task automatic model_edge(input logic r, input logic xb, input logic e);
    logic [63:0] mask;
    for (int i = 0; i < 3; i++) begin
      mask = (64'd1 << plen[i]) - 64'd1;
      if (r) begin
        hist[i]  = '0;
        nbits[i] = 0;
        ey[i]    = 1'b0;
        ecnt[i]  = 0;
      end else if (e) begin
        hist[i] = {hist[i][62:0], xb};
        if (nbits[i] < 1000) nbits[i]++;
        if (nbits[i] >= plen[i] && (hist[i] & mask) == {48'd0, ppat[i]}) begin
          ey[i] = 1'b1;
          if (ecnt[i] < cmax[i]) ecnt[i]++;
          if (!pov[i]) nbits[i] = 0;
        end else begin
          ey[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic step(input string phase, input logic r, input logic xb,
                      input logic e);
    reset = r;
    x     = xb;
    en    = e;
    @(posedge clock);
    model_edge(r, xb, e);
    nstep++;
    #1;
    for (int i = 0; i < 3; i++) begin
      check_val($sformatf("%s y[%0d]", phase, i), 32'(y_dut[i]), 32'(ey[i]));
    end
`ifdef MATCH_CNT_EN
    check_val({phase, " cnt[0]"}, 32'(cnt0), 32'(ecnt[0]));
    check_val({phase, " cnt[1]"}, 32'(cnt1), 32'(ecnt[1]));
    check_val({phase, " cnt[2]"}, 32'(cnt2), 32'(ecnt[2]));
`endif
  endtask

  task automatic send_bits(input string phase, input logic [15:0] bits,
                           input int n);
    for (int i = n - 1; i >= 0; i--) step(phase, 1'b0, bits[i], 1'b1);
  endtask

  initial begin
    logic [7:0] alt;
    alt = 8'b1010_1010;

    // 1: reset with x toggling
    step("rst", 1'b1, 1'b0, 1'b1);
    step("rst", 1'b1, 1'b1, 1'b1);

    // 2/3: 10101010 on overlapping and non-overlapping instances
    send_bits("alt", 16'(alt), 8);
    check_val("alt y_ov_final",  32'(y_dut[0]), 32'd1);
    check_val("alt y_nov_final", 32'(y_dut[1]), 32'd1);
`ifdef MATCH_CNT_EN
    check_val("alt cnt_ov",  32'(cnt0), 32'd3);
    check_val("alt cnt_nov", 32'(cnt1), 32'd2);
`endif

    // 4: gap with en low mid-pattern, then hold in DETECT
    step("gap", 1'b1, 1'b0, 1'b1);
    send_bits("gap", 16'b101, 3);
    for (int i = 0; i < 3; i++) step("gap", 1'b0, 1'($urandom_range(0, 1)), 1'b0);
    step("gap", 1'b0, 1'b0, 1'b1);
    check_val("gap y_detect", 32'(y_dut[0]), 32'd1);
    for (int i = 0; i < 3; i++) step("hold", 1'b0, 1'($urandom_range(0, 1)), 1'b0);
    check_val("hold y_detect", 32'(y_dut[0]), 32'd1);

    // 5: reset lands where bit 4 would complete the pattern
    step("rstmid", 1'b1, 1'b0, 1'b1);
    send_bits("rstmid", 16'b101, 3);
    step("rstmid", 1'b1, 1'b0, 1'b1);
    check_val("rstmid y_after", 32'(y_dut[0]), 32'd0);
    send_bits("rstmid", 16'b1010, 4);
    check_val("rstmid y_fresh", 32'(y_dut[0]), 32'd1);

    // reset while sitting in DETECT
    step("rstdet", 1'b1, 1'b1, 1'b1);
    check_val("rstdet y", 32'(y_dut[0]), 32'd0);

    // 6: all ones into the 111 instance, counter saturates at 3
    send_bits("ones", 16'hFFFF, 8);
    check_val("ones y111", 32'(y_dut[2]), 32'd1);
`ifdef MATCH_CNT_EN
    check_val("ones cnt111", 32'(cnt2), 32'd3);
`endif

    // random traffic
    for (int i = 0; i < 600; i++) begin
      step("rand", ($urandom_range(0, 59) == 0), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 9) < 8));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
